// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the 64-bit pipelined adder and its result buffer.
package adder_pipe_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int STG_WIDTH  = 16;

    // Adder result word: carry-out sits in the MSB above the sum bits.
    typedef logic [DATA_WIDTH:0] result_t;

    // Occupancy counters need one extra bit so that "full" (== depth) fits.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adder_result_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear in the same cycle
// as an increment restarts the count at one, so the new event is not lost.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MaxCount = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear-with-increment gives one, plain increment stops at max.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (clr) begin
                count_d = WIDTH'(1);
            end else if (count_q != MaxCount) begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (clr) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/adder_result_buffer.sv
// Result buffer behind the pipelined adder. The adder cannot be stalled, so
// every flagged result is captured into a small FIFO and handed on through a
// valid/ready port with a registered first-word-fall-through head. Results
// arriving while the FIFO is full are dropped and counted.
module adder_result_buffer
    import adder_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = adder_pipe_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [DATA_WIDTH:0]           i_result,
    output logic                          o_valid,
    output logic [DATA_WIDTH:0]           o_data,
    output logic                          o_carry,
    input  logic                          i_ready,
    output logic [countWidth(DEPTH)-1:0]  o_count,
    output logic                          o_ovf,
    input  logic                          i_ovf_clr,
    output logic [CNT_WIDTH-1:0]          o_drop_cnt
);

    localparam int AddrWidth  = $clog2(DEPTH);
    localparam int CountWidth = countWidth(DEPTH);

    localparam logic [CountWidth-1:0] FullCount = CountWidth'(DEPTH);
    localparam logic [CountWidth-1:0] OneCount  = CountWidth'(1);

    logic [DATA_WIDTH:0]   mem [DEPTH];

    logic [AddrWidth-1:0]  wrPtr_q, wrPtr_d;
    logic [AddrWidth-1:0]  rdPtr_q, rdPtr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH:0]   data_q,  data_d;
    logic                  ovf_q,   ovf_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [AddrWidth-1:0]  nextRdPtr;

    assign full      = (count_q == FullCount);
    assign pop       = valid_q && i_ready;
    assign push      = i_en && (!full || pop);
    assign drop      = i_en && full && !pop;
    assign nextRdPtr = rdPtr_q + AddrWidth'(1);

    // Pointer, occupancy and head-register next state. The head register
    // mirrors mem[rdPtr]; on a pop it loads the following entry, or the
    // incoming word when that word is about to become the only entry.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        data_d  = data_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AddrWidth'(1);
        end
        if (pop) begin
            rdPtr_d = nextRdPtr;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OneCount;
            2'b01:   count_d = count_q - OneCount;
            default: count_d = count_q;
        endcase

        if (pop) begin
            if (count_q != OneCount) begin
                data_d = mem[nextRdPtr];
            end else if (push) begin
                data_d = i_result;
            end
        end else if (push && !valid_q) begin
            data_d = i_result;
        end

        valid_d = (count_d != '0);
        ovf_d   = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);
    end

    // Storage array; contents are meaningless after reset so it has none.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= i_result;
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop),
        .clr   (i_ovf_clr),
        .count (o_drop_cnt)
    );

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_carry = valid_q & data_q[DATA_WIDTH];
    assign o_count = count_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Bench for adder_result_buffer: literal vector table, hand-written corner
// sequences and a random phase compared against a queue-based model.
module tb_adder_result_buffer;
    import adder_pipe_pkg::*;

    localparam int Depth = 4;
    localparam int CW    = $clog2(Depth) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iEn;
    result_t       iResult;
    logic          iReady;
    logic          iOvfClr;

    logic          oValid, oCarry, oOvf;
    result_t       oData;
    logic [CW-1:0] oCount;
    logic [7:0]    oDropCnt;

    logic          oValidB, oCarryB, oOvfB;
    result_t       oDataB;
    logic [CW-1:0] oCountB;
    logic [1:0]    oDropCntB;

    int passCount  = 0;
    int checkCount = 0;

    result_t modelQ[$];
    int      modelDrop;
    bit      modelOvf;

    typedef struct {
        logic          en;
        result_t       data;
        logic          ready;
        logic          clr;
        logic          expValid;
        result_t       expData;
        logic [CW-1:0] expCount;
        logic          expOvf;
        logic [7:0]    expDrop;
    } vec_t;

    vec_t vecs[$];

    adder_result_buffer #(.DATA_WIDTH(64), .DEPTH(Depth), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(iEn), .i_result(iResult),
        .o_valid(oValid), .o_data(oData), .o_carry(oCarry), .i_ready(iReady),
        .o_count(oCount), .o_ovf(oOvf), .i_ovf_clr(iOvfClr), .o_drop_cnt(oDropCnt)
    );

    adder_result_buffer #(.DATA_WIDTH(64), .DEPTH(Depth), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .i_en(iEn), .i_result(iResult),
        .o_valid(oValidB), .o_data(oDataB), .o_carry(oCarryB), .i_ready(iReady),
        .o_count(oCountB), .o_ovf(oOvfB), .i_ovf_clr(iOvfClr), .o_drop_cnt(oDropCntB)
    );

    always #5 clk = ~clk;

    function automatic int capAt(input int raw, input int maxVal);
        return (raw > maxVal) ? maxVal : raw;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance the model by one clock with the given inputs (pre-edge state).
    task automatic modelStep(input logic en, input result_t data,
                             input logic ready, input logic clr);
        bit doPop, doPush, doDrop;
        doPop  = (modelQ.size() != 0) && ready;
        doPush = en && ((modelQ.size() < Depth) || doPop);
        doDrop = en && !doPush;
        if (doPop)  void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(data);
        if (doDrop) begin
            modelOvf  = 1'b1;
            modelDrop = clr ? 1 : modelDrop + 1;
        end else if (clr) begin
            modelOvf  = 1'b0;
            modelDrop = 0;
        end
    endtask

    task automatic applyStimulus(input logic en, input result_t data,
                                 input logic ready, input logic clr);
        iEn = en; iResult = data; iReady = ready; iOvfClr = clr;
        modelStep(en, data, ready, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        bit hasHead;
        hasHead = (modelQ.size() != 0);
        checkOutput({tag, " valid"}, oValid, hasHead);
        if (hasHead) begin
            checkOutput({tag, " data"}, oData, modelQ[0]);
            checkOutput({tag, " carry"}, oCarry, modelQ[0][64]);
        end else begin
            checkOutput({tag, " carry"}, oCarry, 1'b0);
        end
        checkOutput({tag, " count"}, oCount, modelQ.size());
        checkOutput({tag, " ovf"}, oOvf, modelOvf);
        checkOutput({tag, " drop"}, oDropCnt, capAt(modelDrop, 255));
        checkOutput({tag, " dropSat"}, oDropCntB, capAt(modelDrop, 3));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"}, oValid, 1'b0);
        checkOutput({tag, " count"}, oCount, 0);
        checkOutput({tag, " data"}, oData, 0);
        checkOutput({tag, " carry"}, oCarry, 1'b0);
        checkOutput({tag, " ovf"}, oOvf, 1'b0);
        checkOutput({tag, " drop"}, oDropCnt, 0);
        checkOutput({tag, " dropSat"}, oDropCntB, 0);
    endtask

    // Asynchronous reset with i_en held high, then a clean release.
    task automatic doReset(input string tag);
        iEn = 1'b1; iResult = '1; iReady = 1'b0; iOvfClr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkAllZero({tag, " async"});
        @(posedge clk);
        #1;
        checkAllZero({tag, " held"});
        iEn = 1'b0;
        rst_n = 1'b1;
        modelQ.delete();
        modelDrop = 0;
        modelOvf  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " release valid"}, oValid, 1'b0);
    endtask

    task automatic addVec(input logic en, input result_t d, input logic ready,
                          input logic clr, input logic ev, input result_t ed,
                          input int ec, input logic eo, input int edr);
        vec_t v;
        v.en = en; v.data = d; v.ready = ready; v.clr = clr;
        v.expValid = ev; v.expData = ed; v.expCount = CW'(ec);
        v.expOvf = eo; v.expDrop = 8'(edr);
        vecs.push_back(v);
    endtask

    initial begin
        result_t word;
        logic [31:0] rnd;

        rst_n = 1'b0; iEn = 1'b0; iResult = '0; iReady = 1'b0; iOvfClr = 1'b0;
        modelDrop = 0; modelOvf = 1'b0;

        // Fill, overflow, drain; full push+pop; clear versus drop.
        addVec(1, 65'd1, 0, 0, 1, 65'd1, 1, 0, 0);
        addVec(1, 65'd2, 0, 0, 1, 65'd1, 2, 0, 0);
        addVec(1, 65'd3, 0, 0, 1, 65'd1, 3, 0, 0);
        addVec(1, 65'd4, 0, 0, 1, 65'd1, 4, 0, 0);
        addVec(1, 65'd5, 0, 0, 1, 65'd1, 4, 1, 1);
        addVec(1, 65'd6, 0, 0, 1, 65'd1, 4, 1, 2);
        addVec(0, 65'd0, 1, 0, 1, 65'd2, 3, 1, 2);
        addVec(0, 65'd0, 1, 0, 1, 65'd3, 2, 1, 2);
        addVec(0, 65'd0, 1, 0, 1, 65'd4, 1, 1, 2);
        addVec(0, 65'd0, 1, 0, 0, 65'd0, 0, 1, 2);
        addVec(0, 65'd0, 0, 1, 0, 65'd0, 0, 0, 0);
        addVec(1, 65'd1, 0, 0, 1, 65'd1, 1, 0, 0);
        addVec(1, 65'd2, 0, 0, 1, 65'd1, 2, 0, 0);
        addVec(1, 65'h1_FFFF_FFFF_FFFF_FFFF, 0, 0, 1, 65'd1, 3, 0, 0);
        addVec(1, 65'd4, 0, 0, 1, 65'd1, 4, 0, 0);
        addVec(1, 65'd7, 1, 0, 1, 65'd2, 4, 0, 0);
        addVec(0, 65'd0, 1, 0, 1, 65'h1_FFFF_FFFF_FFFF_FFFF, 3, 0, 0);
        addVec(0, 65'd0, 1, 0, 1, 65'd4, 2, 0, 0);
        addVec(0, 65'd0, 1, 0, 1, 65'd7, 1, 0, 0);
        addVec(0, 65'd0, 1, 0, 0, 65'd0, 0, 0, 0);
        addVec(1, 65'd1, 0, 0, 1, 65'd1, 1, 0, 0);
        addVec(1, 65'd2, 0, 0, 1, 65'd1, 2, 0, 0);
        addVec(1, 65'd3, 0, 0, 1, 65'd1, 3, 0, 0);
        addVec(1, 65'd4, 0, 0, 1, 65'd1, 4, 0, 0);
        addVec(1, 65'd5, 0, 1, 1, 65'd1, 4, 1, 1);
        addVec(0, 65'd0, 0, 1, 1, 65'd1, 4, 0, 0);

        doReset("reset");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].data, vecs[i].ready, vecs[i].clr);
            checkOutput($sformatf("vec%0d valid", i), oValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d count", i), oCount, vecs[i].expCount);
            checkOutput($sformatf("vec%0d ovf", i), oOvf, vecs[i].expOvf);
            checkOutput($sformatf("vec%0d drop", i), oDropCnt, vecs[i].expDrop);
            checkOutput($sformatf("vec%0d carry", i), oCarry,
                        vecs[i].expValid & vecs[i].expData[64]);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d data", i), oData, vecs[i].expData);
            end
        end

        // Single word with carry, held while the consumer stalls.
        doReset("reset single");
        applyStimulus(1, 65'h1_0000_0000_0000_0001, 0, 0);
        checkOutput("single valid", oValid, 1'b1);
        checkOutput("single data", oData, 65'h1_0000_0000_0000_0001);
        checkOutput("single carry", oCarry, 1'b1);
        checkOutput("single count", oCount, 1);
        applyStimulus(0, 65'd0, 0, 0);
        applyStimulus(0, 65'd0, 0, 0);
        checkOutput("single hold data", oData, 65'h1_0000_0000_0000_0001);
        checkOutput("single hold valid", oValid, 1'b1);
        applyStimulus(0, 65'd0, 1, 0);
        checkOutput("single popped valid", oValid, 1'b0);
        checkOutput("single popped carry", oCarry, 1'b0);
        checkOutput("single popped count", oCount, 0);

        // Five drops: the 2-bit counter saturates at 3.
        doReset("reset sat");
        for (int k = 1; k <= 4; k++) applyStimulus(1, 65'(k), 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 65'(k + 10), 0, 0);
        checkOutput("sat drop8", oDropCnt, 5);
        checkOutput("sat drop2", oDropCntB, 3);
        checkOutput("sat ovf", oOvf, 1'b1);
        checkOutput("sat count", oCount, 4);

        // Reset in the middle of a drain.
        applyStimulus(0, 65'd0, 1, 0);
        checkOutput("middrain data", oData, 65'd2);
        checkOutput("middrain count", oCount, 3);
        doReset("reset middrain");

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom();
            word[31:0]  = $urandom();
            word[63:32] = $urandom();
            word[64]    = rnd[0];
            applyStimulus(($urandom_range(0, 9) < 7), word,
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
            checkModel($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
